fpu_req_sequencer: RTL and testbench

- Upstream issue stage for fpu_top.
- Buffers tagged operation requests (din1, din2, op_sel) in a small FIFO and issues them to the FPU one at a time with a single-cycle valid pulse.
- Waits for the FPU ready, captures the result, and returns it to the requester with its tag over a valid/ready handshake.
- A watchdog flags operations the FPU never completes.

---
 rtl/fpu_req_sequencer_pkg.sv | 33 +++
 rtl/fpu_req_sequencer_seq_fifo.sv | 53 +++++
 rtl/fpu_req_sequencer.sv | 145 ++++++++++++++
 tb/tb_fpu_req_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_req_sequencer_pkg.sv
// Shared types and default sizing for the FPU request sequencer.
package fpu_req_sequencer_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int OP_W_DEF    = 2;
  localparam int TAG_W_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_MUL = 2'd2,
    FPU_DIV = 2'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Field widths follow the package defaults; the top-level width
  // parameters are expected to match them.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] din1;
    logic [DATA_W_DEF-1:0] din2;
    fpu_op_e               op;
    logic [TAG_W_DEF-1:0]  tag;
  } fpu_req_t;

endpackage

// File: rtl/fpu_req_sequencer_seq_fifo.sv
// Synchronous request FIFO; pointers wrap naturally because DEPTH is a power of 2.
module seq_fifo
  import fpu_req_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  fpu_req_t         push_data_i,
  input  logic             pop_i,
  output fpu_req_t         pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fpu_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fpu_req_sequencer.sv
// Issue stage in front of fpu_top: queues tagged requests, issues one at a
// time, captures the result (or a watchdog abort) and hands it back.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no op in flight; pop the FIFO head when one is queued
// ST_ISSUE | single-cycle fpu_valid pulse with operands from op reg
// ST_WAIT  | waiting for fpu_ready; watchdog counts up
// ST_RESP  | response presented; held until rsp_ready
module fpu_req_sequencer
  import fpu_req_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_din1,
  input  logic [DATA_W-1:0] req_din2,
  input  logic [OP_W-1:0]   req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] fpu_din1,
  output logic [DATA_W-1:0] fpu_din2,
  output logic [OP_W-1:0]   fpu_op_sel,
  output logic              fpu_valid,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic              fpu_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_e        state_q, state_d;
  fpu_req_t          op_q, op_d;
  fpu_req_t          fifo_head;
  fpu_req_t          fifo_in;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // req_ready is held low while reset is asserted so nothing is accepted then.
  assign req_ready = !reset && !fifo_full;

  assign fifo_in.din1 = req_din1;
  assign fifo_in.din2 = req_din2;
  assign fifo_in.op   = fpu_op_e'(req_op);
  assign fifo_in.tag  = req_tag;

  seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_valid && req_ready),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // State, op register, watchdog and captured response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      wdog_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdog_q  <= wdog_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a real result beats a watchdog abort in the same cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wdog_d   = wdog_q;
    res_d    = res_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        if (fpu_ready) begin
          res_d   = fpu_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fpu_valid  = (state_q == ST_ISSUE);
  assign fpu_din1   = op_q.din1;
  assign fpu_din2   = op_q.din2;
  assign fpu_op_sel = op_q.op;

  // Response bus is zero whenever no response is being presented.
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_valid ? res_q : '0;
  assign rsp_tag    = rsp_valid ? op_q.tag : '0;
  assign rsp_err    = rsp_valid && err_q;

  assign busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Directed bench for fpu_req_sequencer with a behavioural FPU stub.
module tb_fpu_req_sequencer;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 2;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_din1 = '0;
  logic [DATA_W-1:0] req_din2 = '0;
  logic [OP_W-1:0]   req_op = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [DATA_W-1:0] fpu_din1;
  logic [DATA_W-1:0] fpu_din2;
  logic [OP_W-1:0]   fpu_op_sel;
  logic              fpu_valid;
  logic [DATA_W-1:0] fpu_result = '0;
  logic              fpu_ready = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fpu_req_sequencer #(
    .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din1(req_din1), .req_din2(req_din2), .req_op(req_op), .req_tag(req_tag),
    .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_op_sel(fpu_op_sel),
    .fpu_valid(fpu_valid), .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // fpu_valid pulse monitor
  int valid_cnt = 0;
  always @(negedge clk) if (fpu_valid) valid_cnt++;

  // FPU stub: ready stub_delay cycles after the valid cycle (0 = never).
  int          stub_delay = 0;
  logic        stub_fixed = 1'b0;
  logic [31:0] stub_value = '0;
  int          stub_cnt = 0;
  int          pulse_req = 0;
  int          pulse_seen = 0;
  always @(negedge clk) begin
    fpu_ready = 1'b0;
    if (reset) stub_cnt = 0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        fpu_ready  = 1'b1;
        fpu_result = stub_fixed ? stub_value : (fpu_din1 ^ fpu_din2);
      end
    end
    if (pulse_req != pulse_seen) begin
      pulse_seen = pulse_req;
      fpu_ready  = 1'b1;
      fpu_result = 32'hDEAD_BEEF;
    end
    if (fpu_valid && stub_delay > 0 && !reset) stub_cnt = stub_delay;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d1, input logic [31:0] d2,
                      input logic [1:0] op, input logic [3:0] tag, output int acc);
    req_valid = 1'b1; req_din1 = d1; req_din2 = d2; req_op = op; req_tag = tag;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL push_accept: tag %0d not accepted within 50 cycles", tag);
    end
  endtask

  task automatic wait_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (fpu_valid) begin
        vcyc = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (vcyc < 0) begin
      errors++;
      $display("FAIL wait_valid: no fpu_valid within 20 cycles");
    end
  endtask

  task automatic wait_rsp(input int limit, output int rcyc);
    rcyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) begin
        rcyc = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (rcyc < 0) begin
      errors++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles", limit);
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, fpu_valid, rsp_valid, rsp_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {req_ready, fpu_valid, rsp_valid, rsp_err, busy});
    end
    checks++;
    if ({fpu_din1, fpu_din2, rsp_result, rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero",
               fpu_din1, fpu_din2, rsp_result, rsp_tag);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: req_ready,busy got %b expected 10", {req_ready, busy});
    end
  endtask

  task automatic test_single();
    int acc, vcyc, rcyc, vc0;
    stub_fixed = 1'b1; stub_value = 32'h4040_0000; stub_delay = 3;
    vc0 = valid_cnt;
    push(32'h3F80_0000, 32'h4000_0000, 2'd0, 4'd5, acc);
    wait_valid(vcyc);
    checks++;
    if (vcyc !== acc + 1) begin
      errors++;
      $display("FAIL single_issue_lat: valid at cycle %0d expected %0d", vcyc, acc + 1);
    end
    checks++;
    if ({fpu_din1, fpu_din2, fpu_op_sel} !== {32'h3F80_0000, 32'h4000_0000, 2'd0}) begin
      errors++;
      $display("FAIL single_operands: got %h %h %0d expected 3f800000 40000000 0",
               fpu_din1, fpu_din2, fpu_op_sel);
    end
    tick();
    checks++;
    if (fpu_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: fpu_valid got %b expected 0 one cycle after issue", fpu_valid);
    end
    wait_rsp(20, rcyc);
    checks++;
    if (rcyc !== vcyc + 4) begin
      errors++;
      $display("FAIL single_rsp_lat: rsp at cycle %0d expected %0d", rcyc, vcyc + 4);
    end
    checks++;
    if ({rsp_result, rsp_tag, rsp_err} !== {32'h4040_0000, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got %h tag %0d err %b expected 40400000 tag 5 err 0",
               rsp_result, rsp_tag, rsp_err);
    end
    accept_rsp();
    checks++;
    if (valid_cnt - vc0 !== 1) begin
      errors++;
      $display("FAIL single_pulse_count: got %0d expected 1", valid_cnt - vc0);
    end
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: rsp_valid,busy got %b expected 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_fill();
    logic [31:0] d1 [5];
    logic [31:0] d2 [5];
    int acc [5];
    int rcyc;
    logic held;
    stub_fixed = 1'b0; stub_delay = 20;
    for (int i = 0; i < 5; i++) begin
      d1[i] = 32'h1000_0000 + 32'(i);
      d2[i] = 32'h0000_0300 * 32'(i + 1);
      push(d1[i], d2[i], 2'(i), 4'(i), acc[i]);
    end
    checks++;
    if (acc[4] !== acc[0] + 4) begin
      errors++;
      $display("FAIL fill_b2b: 5th accepted at %0d expected %0d", acc[4], acc[0] + 4);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: req_ready got %b expected 0", req_ready);
    end
    held = 1'b1;
    req_valid = 1'b1; req_tag = 4'd15; req_din1 = '1; req_din2 = '1;
    for (int i = 0; i < 3; i++) begin
      if (req_ready !== 1'b0) held = 1'b0;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL fill_hold_full: req_ready rose while full, got %b expected 1", held);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp(60, rcyc);
      checks++;
      if ({rsp_result, rsp_tag, rsp_err} !== {d1[i] ^ d2[i], 4'(i), 1'b0}) begin
        errors++;
        $display("FAIL fill_order: got %h tag %0d err %b expected %h tag %0d err 0",
                 rsp_result, rsp_tag, rsp_err, d1[i] ^ d2[i], i);
      end
      accept_rsp();
    end
  endtask

  task automatic test_timeout();
    int acc, vcyc, rcyc;
    logic quiet;
    stub_delay = 0;
    push(32'h4100_0000, 32'h0, 2'd3, 4'd9, acc);
    wait_valid(vcyc);
    wait_rsp(TIMEOUT + 10, rcyc);
    checks++;
    if (rcyc !== vcyc + 1 + TIMEOUT) begin
      errors++;
      $display("FAIL timeout_lat: rsp at %0d expected %0d", rcyc, vcyc + 1 + TIMEOUT);
    end
    checks++;
    if ({rsp_result, rsp_tag, rsp_err} !== {32'h0, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL timeout_rsp: got %h tag %0d err %b expected 00000000 tag 9 err 1",
               rsp_result, rsp_tag, rsp_err);
    end
    accept_rsp();
    pulse_req++;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL timeout_late_ready: late fpu_ready caused activity, got %b expected 1", quiet);
    end
  endtask

  task automatic test_backpressure();
    int acc, vcyc, rcyc, vc0, h;
    logic [36:0] snap;
    logic stable;
    stub_fixed = 1'b0; stub_delay = 2;
    push(32'h0000_00F0, 32'h0000_000F, 2'd2, 4'd1, acc);
    push(32'h1234_0000, 32'h0000_5678, 2'd1, 4'd2, acc);
    wait_rsp(20, rcyc);
    snap = {rsp_result, rsp_tag, rsp_err};
    checks++;
    if (snap !== {32'h0000_00FF, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_first: got %h expected %h", snap, {32'h0000_00FF, 4'd1, 1'b0});
    end
    vc0 = valid_cnt;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || {rsp_result, rsp_tag, rsp_err} !== snap) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable: response changed while stalled, got %b expected 1", stable);
    end
    checks++;
    if (valid_cnt !== vc0) begin
      errors++;
      $display("FAIL bp_no_issue: fpu_valid pulses %0d expected 0", valid_cnt - vc0);
    end
    rsp_ready = 1'b1;
    tick();
    h = cyc;
    rsp_ready = 1'b0;
    wait_valid(vcyc);
    checks++;
    if (vcyc !== h + 1) begin
      errors++;
      $display("FAIL bp_next_issue: issue at %0d expected %0d", vcyc, h + 1);
    end
    wait_rsp(20, rcyc);
    checks++;
    if ({rsp_result, rsp_tag, rsp_err} !== {32'h1234_5678, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL bp_second: got %h tag %0d err %b expected 12345678 tag 2 err 0",
               rsp_result, rsp_tag, rsp_err);
    end
    accept_rsp();
  endtask

  task automatic test_reset_mid();
    int acc, vc0;
    logic quiet;
    stub_delay = 0;
    push(32'h1, 32'h2, 2'd0, 4'd3, acc);
    push(32'h3, 32'h4, 2'd1, 4'd4, acc);
    push(32'h5, 32'h6, 2'd2, 4'd6, acc);
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, fpu_valid, rsp_valid, rsp_err, busy} !== 5'b0 ||
        {fpu_din1, fpu_din2, fpu_op_sel} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: ctrl %b din1 %h din2 %h expected all zero",
               {req_ready, fpu_valid, rsp_valid, rsp_err, busy}, fpu_din1, fpu_din2);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_empty: req_ready,busy got %b expected 10", {req_ready, busy});
    end
    vc0 = valid_cnt;
    pulse_req++;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1 || valid_cnt !== vc0) begin
      errors++;
      $display("FAIL midreset_late_ready: quiet %b pulses %0d expected 1 and 0",
               quiet, valid_cnt - vc0);
    end
  endtask

  task automatic test_simultaneous();
    int acc, vcyc, rcyc;
    stub_fixed = 1'b1; stub_value = 32'h4120_0000; stub_delay = TIMEOUT;
    push(32'h4110_0000, 32'h3F80_0000, 2'd0, 4'd7, acc);
    wait_valid(vcyc);
    wait_rsp(TIMEOUT + 10, rcyc);
    checks++;
    if (rcyc !== vcyc + 1 + TIMEOUT) begin
      errors++;
      $display("FAIL simul_lat: rsp at %0d expected %0d", rcyc, vcyc + 1 + TIMEOUT);
    end
    checks++;
    if ({rsp_result, rsp_tag, rsp_err} !== {32'h4120_0000, 4'd7, 1'b0}) begin
      errors++;
      $display("FAIL simul_ready_wins: got %h tag %0d err %b expected 41200000 tag 7 err 0",
               rsp_result, rsp_tag, rsp_err);
    end
    accept_rsp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
